pll_supervisor: RTL and testbench

//  Parametrised iCE40 PLL block: wraps SB_PLL40_CORE with DIVR/DIVF/DIVQ/FILTER_RANGE exposed
//  as parameters. Adds lock supervision, automatic PLL re-reset and staggered release of
//  NUM_RST downstream reset domains. Sits at FPGA top, between board clock and core clock/reset.

---
 rtl/pll_supervisor.sv | 217 +++++++++++++++++++++
 tb/tb_pll_supervisor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_supervisor.sv
// pll_supervisor
//   iCE40 PLL wrapper with lock supervision, automatic PLL re-reset and staggered
//   release of NUM_RST downstream reset domains. All control logic runs on the
//   free-running reference clock.
//
// Ports
//   clk            in   reference clock (board oscillator), also PLL REFERENCECLK
//   c_sys_rst_n    in   asynchronous active-low reset
//   relock_req     in   1-cycle pulse: force PLL re-reset and full re-sequence
//   pll_lock       in   lock stand-in used only when SYNTHESIS is not defined;
//                       the real build takes LOCK from SB_PLL40_CORE
//   clk_pll        out  PLL output clock (PLLOUTGLOBAL)
//   pll_resetb     out  PLL RESETB
//   rst_n_o        out  active-low domain resets (consumers sync deassert locally)
//   locked         out  sequence complete and lock stable
//   lock_lost_cnt  out  lock losses seen in RELEASE/RUN, saturating at 255
module pll_supervisor #(
  parameter logic [3:0]  DIVR             = 4'b0000,
  parameter logic [6:0]  DIVF             = 7'b0111000,
  parameter logic [2:0]  DIVQ             = 3'b011,
  parameter logic [2:0]  FILTER_RANGE     = 3'b001,
  parameter int unsigned NUM_RST          = 3,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYC = 4096,
  parameter int unsigned STAGGER_CYC      = 8
) (
  input  logic               clk,
  input  logic               c_sys_rst_n,
  input  logic               relock_req,
  input  logic               pll_lock,
  output logic               clk_pll,
  output logic               pll_resetb,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               locked,
  output logic [7:0]         lock_lost_cnt
);

  localparam int unsigned RstW   = $clog2(PLL_RST_CYC + 1);
  localparam int unsigned StbW   = $clog2(LOCK_STABLE_CYC + 1);
  localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int unsigned StgMax = (NUM_RST - 1) * STAGGER_CYC;
  localparam int unsigned StgW   = (StgMax > 0) ? $clog2(StgMax + 1) : 1;

  typedef enum logic [1:0] {
    StPllRst,
    StWaitLock,
    StRelease,
    StRun
  } state_e;

  logic lock_raw;
  logic pll_resetb_q, pll_resetb_d;

  // PLL primitive or simulation stand-in
`ifdef SYNTHESIS
  SB_PLL40_CORE #(
    .FEEDBACK_PATH("SIMPLE"),
    .DIVR         (DIVR),
    .DIVF         (DIVF),
    .DIVQ         (DIVQ),
    .FILTER_RANGE (FILTER_RANGE)
  ) u_pll (
    .REFERENCECLK   (clk),
    .PLLOUTCORE     (),
    .PLLOUTGLOBAL   (clk_pll),
    .EXTFEEDBACK    (1'b0),
    .DYNAMICDELAY   (8'h00),
    .LOCK           (lock_raw),
    .BYPASS         (1'b0),
    .RESETB         (pll_resetb_q),
    .LATCHINPUTVALUE(1'b0),
    .SDI            (1'b0),
    .SCLK           (1'b0),
    .SDO            ()
  );
  logic unused_pll_lock;
  assign unused_pll_lock = pll_lock;
`else
  // Behavioural stand-in: output clock follows the reference, lock comes from the port.
  logic [16:0] unused_pll_cfg;
  assign unused_pll_cfg = {DIVR, DIVF, DIVQ, FILTER_RANGE};
  assign clk_pll        = clk;
  assign lock_raw       = pll_lock;
`endif

  // LOCK is asynchronous to clk
  logic lock_meta_q, lock_s_q;

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_raw;
      lock_s_q    <= lock_meta_q;
    end
  end

  state_e              state_q, state_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [StbW-1:0]     stable_q, stable_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [StgW-1:0]     stg_q, stg_d;
  logic [StgW-1:0]     stg_next;
  logic [NUM_RST-1:0]  rst_n_q, rst_n_d;
  logic                locked_q, locked_d;
  logic [7:0]          lost_q, lost_d;
  logic [NUM_RST-1:0]  stagger_hit;
  logic                fault;

  assign stg_next = stg_q + 1'b1;

  // Bit g deasserts when the release timer reaches g*STAGGER_CYC edges after entry.
  for (genvar g = 0; g < NUM_RST; g++) begin : g_hit
    assign stagger_hit[g] = (stg_next == StgW'(g * STAGGER_CYC));
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stable_d  = stable_q;
    tmo_d     = tmo_q;
    stg_d     = stg_q;
    rst_n_d   = rst_n_q;
    locked_d  = locked_q;
    lost_d    = lost_q;
    fault     = ((state_q == StRelease) || (state_q == StRun)) && !lock_s_q;

    unique case (state_q)
      StPllRst: begin
        if (rst_cnt_q == RstW'(PLL_RST_CYC - 1)) begin
          state_d = StWaitLock;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        // A completed stable window wins over a coincident timeout.
        if (lock_s_q && (stable_q == StbW'(LOCK_STABLE_CYC - 1))) begin
          rst_n_d[0] = 1'b1;
          if (NUM_RST == 1) begin
            locked_d = 1'b1;
            state_d  = StRun;
          end else begin
            state_d  = StRelease;
          end
        end else if (tmo_q == TmoW'(LOCK_TIMEOUT_CYC - 1)) begin
          state_d = StPllRst;
        end else begin
          stable_d = lock_s_q ? stable_q + 1'b1 : '0;
          tmo_d    = tmo_q + 1'b1;
        end
      end
      StRelease: begin
        stg_d   = stg_next;
        rst_n_d = rst_n_q | stagger_hit;
        if (stg_next == StgW'(StgMax)) begin
          locked_d = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: ;
      default: state_d = StPllRst;
    endcase

    // Lock loss or relock request tears everything down; only loss is counted.
    if (fault || (relock_req && (state_q != StPllRst))) begin
      state_d  = StPllRst;
      rst_n_d  = '0;
      locked_d = 1'b0;
    end
    if (fault && (lost_q != 8'hFF)) begin
      lost_d = lost_q + 1'b1;
    end

    // Every state starts with fresh counters.
    if (state_d != state_q) begin
      rst_cnt_d = '0;
      stable_d  = '0;
      tmo_d     = '0;
      stg_d     = '0;
    end

    pll_resetb_d = (state_d != StPllRst);
  end

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      state_q      <= StPllRst;
      rst_cnt_q    <= '0;
      stable_q     <= '0;
      tmo_q        <= '0;
      stg_q        <= '0;
      rst_n_q      <= '0;
      locked_q     <= 1'b0;
      lost_q       <= '0;
      pll_resetb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stable_q     <= stable_d;
      tmo_q        <= tmo_d;
      stg_q        <= stg_d;
      rst_n_q      <= rst_n_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
      pll_resetb_q <= pll_resetb_d;
    end
  end

  assign pll_resetb    = pll_resetb_q;
  assign rst_n_o       = rst_n_q;
  assign locked        = locked_q;
  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor
//   Bench for pll_supervisor with short timing parameters. A per-edge reference model
//   (phase + elapsed-edge arithmetic, lock history queue) is compared on every edge,
//   alongside a table of fixed release timings and hand-written corner sequences.
module tb_pll_supervisor;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int STG = 2;
  localparam int NR  = 3;

  logic          clk = 1'b0;
  logic          c_sys_rst_n = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_lock = 1'b0;
  logic          clk_pll;
  logic          pll_resetb;
  logic [NR-1:0] rst_n_o;
  logic          locked;
  logic [7:0]    lock_lost_cnt;

  pll_supervisor #(
    .NUM_RST         (NR),
    .PLL_RST_CYC     (PRC),
    .LOCK_STABLE_CYC (LSC),
    .LOCK_TIMEOUT_CYC(LTC),
    .STAGGER_CYC     (STG)
  ) dut (
    .clk          (clk),
    .c_sys_rst_n  (c_sys_rst_n),
    .relock_req   (relock_req),
    .pll_lock     (pll_lock),
    .clk_pll      (clk_pll),
    .pll_resetb   (pll_resetb),
    .rst_n_o      (rst_n_o),
    .locked       (locked),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  // Reference model: phase 0 = PLL held in reset, 1 = waiting for lock,
  // 2 = released (staggered bits and locked derived from elapsed edges).
  int m_phase, m_since, m_run, m_cnt;
  bit hist[$];

  typedef struct {
    int         edge_n;
    logic       resetb;
    logic [2:0] rst;
    logic       lck;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [31:0] pack(input logic rb, input logic [2:0] r, input logic l,
                                       input logic [7:0] c);
    return {19'd0, rb, r, l, c};
  endfunction

  function automatic logic [31:0] dut_out();
    return pack(pll_resetb, rst_n_o, locked, lock_lost_cnt);
  endfunction

  function automatic logic [31:0] model_out();
    logic [2:0] r;
    logic       l;
    r = '0;
    for (int i = 0; i < NR; i++) begin
      if (m_phase == 2 && m_since >= i * STG) r[i] = 1'b1;
    end
    l = (m_phase == 2) && (m_since >= (NR - 1) * STG);
    return pack(m_phase != 0, r, l, 8'(m_cnt));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=0x%0h want=0x%0h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_since = 0;
    m_run   = 0;
    m_cnt   = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit lk, input bit rq);
    bit ls;
    ls = hist.pop_front();  // lock as seen through two synchroniser stages
    hist.push_back(lk);
    case (m_phase)
      0: begin
        m_since++;
        if (m_since == PRC) begin
          m_phase = 1;
          m_since = 0;
          m_run   = 0;
        end
      end
      1: begin
        if (rq) begin
          m_phase = 0;
          m_since = 0;
        end else begin
          m_run = ls ? m_run + 1 : 0;
          m_since++;
          if (m_run == LSC) begin
            m_phase = 2;
            m_since = 0;
          end else if (m_since == LTC) begin
            m_phase = 0;
            m_since = 0;
          end
        end
      end
      default: begin
        if (!ls || rq) begin
          if (!ls && m_cnt < 255) m_cnt++;
          m_phase = 0;
          m_since = 0;
        end else begin
          m_since++;
        end
      end
    endcase
  endtask

  task automatic tick();
    bit lk, rq;
    lk = pll_lock;
    rq = relock_req;
    @(posedge clk);
    model_step(lk, rq);
    edge_no++;
    #1;
    check("model", dut_out(), model_out());
  endtask

  // Asynchronous reset between edges, checked immediately, then released.
  task automatic apply_reset(input logic lk);
    #2;
    c_sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_out(), pack(1'b0, 3'b000, 1'b0, 8'd0));
    @(posedge clk);
    #1;
    pll_lock    = lk;
    relock_req  = 1'b0;
    c_sys_rst_n = 1'b1;
    edge_no     = 0;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < 9; i++) begin
      while (edge_no < tbl[i].edge_n) tick();
      check(name, dut_out(), pack(tbl[i].resetb, tbl[i].rst, tbl[i].lck, tbl[i].cnt));
    end
  endtask

  task automatic wait_locked(input string name);
    int n;
    n = 0;
    while (!locked && n < 200) begin
      tick();
      n++;
    end
    if (!locked) check(name, {31'd0, locked}, 32'd1);
  endtask

  initial begin
    int drop_left;

    tbl[0] = '{3,  1'b0, 3'b000, 1'b0, 8'd0};
    tbl[1] = '{4,  1'b1, 3'b000, 1'b0, 8'd0};
    tbl[2] = '{11, 1'b1, 3'b000, 1'b0, 8'd0};
    tbl[3] = '{12, 1'b1, 3'b001, 1'b0, 8'd0};
    tbl[4] = '{13, 1'b1, 3'b001, 1'b0, 8'd0};
    tbl[5] = '{14, 1'b1, 3'b011, 1'b0, 8'd0};
    tbl[6] = '{15, 1'b1, 3'b011, 1'b0, 8'd0};
    tbl[7] = '{16, 1'b1, 3'b111, 1'b1, 8'd0};
    tbl[8] = '{20, 1'b1, 3'b111, 1'b1, 8'd0};

    model_reset();
    #12;
    check("reset_state", dut_out(), pack(1'b0, 3'b000, 1'b0, 8'd0));

    // Clean lock from reset
    apply_reset(1'b1);
    run_table("clean_seq");

    // Lock loss in RUN
    pll_lock = 1'b0;
    repeat (3) tick();
    check("lock_loss", dut_out(), pack(1'b0, 3'b000, 1'b0, 8'd1));
    pll_lock = 1'b1;
    wait_locked("relock_after_loss");
    check("relocked", dut_out(), pack(1'b1, 3'b111, 1'b1, 8'd1));

    // relock_req in RUN: uncounted
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_req", dut_out(), pack(1'b0, 3'b000, 1'b0, 8'd1));
    wait_locked("relock_req_wait");

    // relock_req coinciding with a fault: counted once
    pll_lock = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("fault_plus_relock", dut_out(), pack(1'b0, 3'b000, 1'b0, 8'd2));

    // Single-cycle lock glitch during WAIT_LOCK restarts the stable window
    apply_reset(1'b1);
    repeat (6) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    while (edge_no < 16) tick();
    check("glitch_no_early", dut_out(), pack(1'b1, 3'b000, 1'b0, 8'd0));
    tick();
    check("glitch_release", dut_out(), pack(1'b1, 3'b001, 1'b0, 8'd0));

    // No lock at all: PLL reset retried every PRC+LTC edges
    apply_reset(1'b0);
    for (int e = 1; e <= 80; e++) begin
      tick();
      check("timeout_cycle", dut_out(),
            pack((e >= PRC) && (((e - PRC) % (PRC + LTC)) < LTC), 3'b000, 1'b0, 8'd0));
    end

    // Async reset between rst_n_o[0] and rst_n_o[1] release, then a clean rerun
    apply_reset(1'b1);
    while (edge_no < 13) tick();
    check("mid_release", dut_out(), pack(1'b1, 3'b001, 1'b0, 8'd0));
    apply_reset(1'b1);
    run_table("after_async_reset");

    // Randomised lock drops, long outages and relock pulses
    apply_reset(1'b1);
    drop_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (drop_left > 0) begin
        pll_lock = 1'b0;
        drop_left--;
      end else begin
        pll_lock = 1'b1;
        if ($urandom_range(59) == 0) begin
          drop_left = ($urandom_range(9) == 0) ? 40 : int'($urandom_range(4, 1));
        end
      end
      relock_req = ($urandom_range(249) == 0);
      tick();
    end
    relock_req = 1'b0;

    // Saturation of the loss counter
    apply_reset(1'b1);
    for (int f = 0; f < 260; f++) begin
      pll_lock = 1'b1;
      wait_locked("sat_wait");
      pll_lock = 1'b0;
      repeat (3) tick();
    end
    check("cnt_saturate", {24'd0, lock_lost_cnt}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
